// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_ctrl_pkg : shared encodings for the multi-cycle ARM control unit        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package mc_ctrl_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEMADR   = STATE_W'(2),
        S_MEMRD    = STATE_W'(3),
        S_MEMWB    = STATE_W'(4),
        S_MEMWR    = STATE_W'(5),
        S_EXECUTER = STATE_W'(6),
        S_EXECUTEI = STATE_W'(7),
        S_ALUWB    = STATE_W'(8),
        S_BRANCH   = STATE_W'(9),
        S_UNKNOWN  = STATE_W'(10),
        S_HALT     = STATE_W'(11)
    } state_e;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_ALUOUT    = 1'b1;
    localparam logic [1:0] SRCA_RD1      = 2'd0;
    localparam logic [1:0] SRCA_PC       = 2'd1;
    localparam logic [1:0] SRCB_RD2      = 2'd0;
    localparam logic [1:0] SRCB_IMM      = 2'd1;
    localparam logic [1:0] SRCB_FOUR     = 2'd2;
    localparam logic [1:0] RES_ALUOUT    = 2'd0;
    localparam logic [1:0] RES_DATA      = 2'd1;
    localparam logic [1:0] RES_ALURESULT = 2'd2;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];
        case (cond)
            4'b0000: cond_eval = z;
            4'b0001: cond_eval = ~z;
            4'b0010: cond_eval = c;
            4'b0011: cond_eval = ~c;
            4'b0100: cond_eval = n;
            4'b0101: cond_eval = ~n;
            4'b0110: cond_eval = v;
            4'b0111: cond_eval = ~v;
            4'b1000: cond_eval = c & ~z;
            4'b1001: cond_eval = ~c | z;
            4'b1010: cond_eval = (n == v);
            4'b1011: cond_eval = (n != v);
            4'b1100: cond_eval = ~z & (n == v);
            4'b1101: cond_eval = z | (n != v);
            4'b1110: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_controller_cond_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_cond_unit : NZCV flags register, condition check and write qualifying   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mc_cond_unit
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       Reset,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic       capture_i,
    input  logic       flag_wr_i,
    input  logic       cv_wr_i,
    input  logic       reg_w_i,
    input  logic       mem_w_i,
    input  logic       pcs_i,
    input  logic       next_pc_i,
    output logic       reg_write_o,
    output logic       mem_write_o,
    output logic       pc_write_o
);

    logic [3:0] flags_q, flags_d;
    logic       cond_ex_q, cond_ex_d;

    always_comb begin
        flags_d   = flags_q;
        cond_ex_d = capture_i ? cond_eval(cond_i, flags_q) : cond_ex_q;
        if (flag_wr_i && cond_ex_q) begin
            flags_d[FLAG_N] = alu_flags_i[FLAG_N];
            flags_d[FLAG_Z] = alu_flags_i[FLAG_Z];
            // Logical ops leave carry/overflow as they were
            if (cv_wr_i) begin
                flags_d[FLAG_C] = alu_flags_i[FLAG_C];
                flags_d[FLAG_V] = alu_flags_i[FLAG_V];
            end
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    // Reset gates the enables so they drop the instant reset is asserted
    assign reg_write_o = Reset & reg_w_i & cond_ex_q;
    assign mem_write_o = Reset & mem_w_i & cond_ex_q;
    assign pc_write_o  = Reset & (next_pc_i | (pcs_i & cond_ex_q));

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_controller : multi-cycle ARM control unit (FSM + decode + cond unit)    |
// | Optional MC_ILLEGAL_HALT_EN: illegal instructions halt the FSM.  Rev 1.0   |
// +----------------------------------------------------------------------------+
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         Reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         IRWrite,
    output logic         MemWrite,
    output logic         RegWrite,
    output logic         AdrSrc,
    output logic [1:0]   RegSrc,
    output logic [1:0]   ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ResultSrc,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   ALUControl,
    output logic         Halted
);

    state_e     state_q, state_d;
    logic [3:0] cond, cmd;
    logic [1:0] op;
    logic [5:0] funct;
    logic       rd15, cmd_legal, unused_rn;
    logic       ir_write, next_pc, reg_w, mem_w, branch, alu_op;
    logic       flag_wr, cv_wr, pcs;

    assign cond      = Instr[31:28];
    assign op        = Instr[27:26];
    assign funct     = Instr[25:20];
    assign cmd       = funct[4:1];
    assign rd15      = (Instr[15:12] == 4'hF);
    assign unused_rn = ^Instr[19:16];
    assign cmd_legal = cmd inside {CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR};

`ifdef MC_ILLEGAL_HALT_EN
    logic illegal;
    assign illegal = (op == 2'b11) || ((op == OP_DP) && !cmd_legal) || (cond == 4'b1111);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
`ifdef MC_ILLEGAL_HALT_EN
                if (illegal)
                    state_d = S_HALT;
                else
`endif
                if (op == OP_MEM)
                    state_d = S_MEMADR;
                else if (op == OP_DP)
                    state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                else if (op == OP_BR)
                    state_d = S_BRANCH;
                else
                    state_d = S_UNKNOWN;
            end
            S_MEMADR:   state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
`ifdef MC_ILLEGAL_HALT_EN
            S_HALT:     state_d = S_HALT;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        ir_write  = 1'b0;
        next_pc   = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        branch    = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = ADR_PC;
        ALUSrcA   = SRCA_RD1;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                next_pc   = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR: ALUSrcB = SRCB_IMM;
            S_MEMRD:  AdrSrc  = ADR_ALUOUT;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = ADR_ALUOUT;
                mem_w  = 1'b1;
            end
            S_EXECUTER: alu_op = 1'b1;
            S_EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                alu_op  = 1'b1;
            end
            // An unsupported ALU command retires as a NOP
            S_ALUWB: reg_w = cmd_legal;
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ALUControl = ALU_ADD;
        if (alu_op) begin
            case (cmd)
                CMD_SUB: ALUControl = ALU_SUB;
                CMD_AND: ALUControl = ALU_AND;
                CMD_ORR: ALUControl = ALU_ORR;
                default: ALUControl = ALU_ADD;
            endcase
        end
    end

    assign flag_wr = ((state_q == S_EXECUTER) || (state_q == S_EXECUTEI)) && funct[0] && cmd_legal;
    assign cv_wr   = (cmd == CMD_ADD) || (cmd == CMD_SUB);
    assign pcs     = branch | (reg_w & rd15);
    assign RegSrc  = {(op == OP_MEM), (op == OP_BR)};
    assign ImmSrc  = op;
    assign IRWrite = Reset & ir_write;

`ifdef MC_ILLEGAL_HALT_EN
    assign Halted = Reset & (state_q == S_HALT);
`else
    assign Halted = 1'b0;
`endif

    mc_cond_unit u_cond (
        .clk         (clk),
        .Reset       (Reset),
        .cond_i      (cond),
        .alu_flags_i (ALUFlags),
        .capture_i   (state_q == S_DECODE),
        .flag_wr_i   (flag_wr),
        .cv_wr_i     (cv_wr),
        .reg_w_i     (reg_w),
        .mem_w_i     (mem_w),
        .pcs_i       (pcs),
        .next_pc_i   (next_pc),
        .reg_write_o (RegWrite),
        .mem_write_o (MemWrite),
        .pc_write_o  (PCWrite)
    );

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mc_controller : directed scoreboard bench for mc_controller             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mc_controller;
    import mc_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         Reset;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, Halted;
    logic [1:0]   RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

    mc_controller dut (
        .clk        (clk),
        .Reset      (Reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .Halted     (Halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, memw, regw, adr, halted;
        logic [1:0] srca, srcb, res, aluc, regsrc, immsrc;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    logic [1:0] cur_rs, cur_is;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic exp_t observe();
        exp_t o;
        o.st = dut.state_q;
        o.pcw = PCWrite; o.irw = IRWrite; o.memw = MemWrite; o.regw = RegWrite;
        o.adr = AdrSrc; o.halted = Halted;
        o.srca = ALUSrcA; o.srcb = ALUSrcB; o.res = ResultSrc; o.aluc = ALUControl;
        o.regsrc = RegSrc; o.immsrc = ImmSrc;
        return o;
    endfunction

    task automatic p(input logic [3:0] st, input logic pcw, irw, memw, regw, adr,
                     input logic [1:0] srca, srcb, res, aluc);
        exp_t e;
        e.st = st; e.pcw = pcw; e.irw = irw; e.memw = memw; e.regw = regw;
        e.adr = adr; e.halted = 1'b0;
        e.srca = srca; e.srcb = srcb; e.res = res; e.aluc = aluc;
        e.regsrc = cur_rs; e.immsrc = cur_is;
        sb.push_back(e);
    endtask

    task automatic p_halt();
        exp_t e;
        e = '0;
        e.st = S_HALT; e.halted = 1'b1; e.regsrc = cur_rs; e.immsrc = cur_is;
        sb.push_back(e);
    endtask

    task automatic p_fd();
        p(S_FETCH,  1, 1, 0, 0, 0, 1, 2, 2, 0);
        p(S_DECODE, 0, 0, 0, 0, 0, 1, 2, 2, 0);
    endtask

    task automatic load(input logic [31:0] v, input logic [3:0] fl,
                        input logic [1:0] rs, input logic [1:0] is);
        Instr = v[31:12];
        ALUFlags = fl;
        cur_rs = rs;
        cur_is = is;
        #1;
    endtask

    // Compare one scoreboard entry per cycle, then step to the next cycle
    task automatic drain(input string tag);
        exp_t e;
        int n;
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s.c%0d", tag, n), {10'd0, observe()}, {10'd0, e});
            n++;
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b0; Instr = '0; ALUFlags = 4'h0; cur_rs = 2'b00; cur_is = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", {28'd0, dut.state_q}, {28'd0, S_FETCH});
        chk("rst_en",    {27'd0, PCWrite, IRWrite, MemWrite, RegWrite, Halted}, 32'd0);
        chk("rst_sel",   {23'd0, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl},
                         {23'd0, 1'b0, 2'd1, 2'd2, 2'd2, 2'd0});
        chk("rst_flags", {28'd0, dut.u_cond.flags_q}, 32'd0);
        Reset = 1'b1;
        #1;

        // ADD R1,R2,R3 with S=0: flags must ignore ALUFlags
        load(32'hE0821003, 4'hF, 2'b00, 2'b00);
        p_fd();
        p(S_EXECUTER, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        p(S_ALUWB,    0, 0, 0, 1, 0, 0, 0, 0, 0);
        drain("add");
        chk("add_flags", {28'd0, dut.u_cond.flags_q}, 32'd0);

        load(32'hE5921004, 4'h0, 2'b10, 2'b01);
        p_fd();
        p(S_MEMADR, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        p(S_MEMRD,  0, 0, 0, 0, 1, 0, 0, 0, 0);
        p(S_MEMWB,  0, 0, 0, 1, 0, 0, 0, 1, 0);
        drain("ldr");

        load(32'hE5821004, 4'h0, 2'b10, 2'b01);
        p_fd();
        p(S_MEMADR, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        p(S_MEMWR,  0, 0, 1, 0, 1, 0, 0, 0, 0);
        drain("str");

        load(32'hE0500000, 4'b0110, 2'b00, 2'b00);
        p_fd();
        p(S_EXECUTER, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01);
        p(S_ALUWB,    0, 0, 0, 1, 0, 0, 0, 0, 0);
        drain("subs");
        chk("subs_flags", {28'd0, dut.u_cond.flags_q}, 32'h6);

        load(32'h0A000002, 4'h0, 2'b01, 2'b10);
        p_fd();
        p(S_BRANCH, 1, 0, 0, 0, 0, 0, 1, 2, 0);
        drain("beq_taken");

        load(32'h1A000002, 4'h0, 2'b01, 2'b10);
        p_fd();
        p(S_BRANCH, 0, 0, 0, 0, 0, 0, 1, 2, 0);
        drain("bne_not_taken");

        load(32'h10821003, 4'b1001, 2'b00, 2'b00);
        p_fd();
        p(S_EXECUTER, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        p(S_ALUWB,    0, 0, 0, 0, 0, 0, 0, 0, 0);
        drain("addne");
        chk("addne_flags", {28'd0, dut.u_cond.flags_q}, 32'h6);

        load(32'hE08FF003, 4'h0, 2'b00, 2'b00);
        p_fd();
        p(S_EXECUTER, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        p(S_ALUWB,    1, 0, 0, 1, 0, 0, 0, 0, 0);
        drain("add_pc");

        // ORRS imm: NZ from ALU (10), C/V retained from 0110 -> 1010
        load(32'hE3921001, 4'b1001, 2'b00, 2'b00);
        p_fd();
        p(S_EXECUTEI, 0, 0, 0, 0, 0, 0, 1, 0, 2'b11);
        p(S_ALUWB,    0, 0, 0, 1, 0, 0, 0, 0, 0);
        drain("orrs");
        chk("orrs_flags", {28'd0, dut.u_cond.flags_q}, 32'hA);

        // Reset in the middle of a store
        load(32'hE5821004, 4'h0, 2'b10, 2'b01);
        p_fd();
        p(S_MEMADR, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        drain("str2");
        chk("memwr_before_rst", {31'd0, MemWrite}, 32'd1);
        #2 Reset = 1'b0;
        #1;
        chk("memwr_in_rst", {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 32'd0);
        chk("state_in_rst", {28'd0, dut.state_q}, {28'd0, S_FETCH});
        repeat (2) @(negedge clk);
        Reset = 1'b1;
        #1;
        chk("flags_after_rst", {28'd0, dut.u_cond.flags_q}, 32'd0);

        load(32'h0A000002, 4'h0, 2'b01, 2'b10);
        p_fd();
        p(S_BRANCH, 0, 0, 0, 0, 0, 0, 1, 2, 0);
        drain("beq_after_rst");

`ifdef MC_ILLEGAL_HALT_EN
        load(32'hEC000000, 4'h0, 2'b00, 2'b11);
        p_fd();
        for (int i = 0; i < 20; i++) p_halt();
        drain("undef_halt");
        Reset = 1'b0;
        repeat (2) @(negedge clk);
        Reset = 1'b1;
        #1;
        load(32'hE0321003, 4'hF, 2'b00, 2'b00);
        p_fd();
        for (int i = 0; i < 3; i++) p_halt();
        drain("eors_halt");
`else
        // Illegal ALU command with S=1: executes as ADD, no write, no flag update
        load(32'hE0321003, 4'hF, 2'b00, 2'b00);
        p_fd();
        p(S_EXECUTER, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        p(S_ALUWB,    0, 0, 0, 0, 0, 0, 0, 0, 0);
        drain("eors_nop");
        chk("eors_flags", {28'd0, dut.u_cond.flags_q}, 32'd0);

        load(32'hEC000000, 4'h0, 2'b00, 2'b11);
        p_fd();
        p(S_UNKNOWN, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        p(S_FETCH,   1, 1, 0, 0, 0, 1, 2, 2, 0);
        drain("undef_nop");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
